// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared definitions for the instruction-cache line blocks:
//                fill-sequencer state encoding and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default geometry, shared with the cache RAM and tag blocks
    localparam int c_default_num_lines  = 32;
    localparam int c_default_line_bytes = 16;

    // Line-fill sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_valid_array.sv
`default_nettype none
// ============================================================================
//  Module      : cache_valid_array
//  Description : One valid flop per cache line with binary-indexed lookup,
//                flush, single-line invalidate, set and clear. Updates on
//                the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_valid_array #(
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 flush,
    input  logic                 inval,
    input  logic [IDX_W-1:0]     inval_line,
    input  logic                 set_en,
    input  logic [IDX_W-1:0]     set_line,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_line,
    input  logic [IDX_W-1:0]     lookup_line,
    output logic                 hit,
    output logic [NUM_LINES-1:0] valid_bits
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] w_valid_next;

    // Next value per line: flush beats inval beats set beats clear
    always_comb begin
        w_valid_next = r_valid;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (flush) begin
                w_valid_next[i] = 1'b0;
            end else if (inval && (inval_line == IDX_W'(i))) begin
                w_valid_next[i] = 1'b0;
            end else if (set_en && (set_line == IDX_W'(i))) begin
                w_valid_next[i] = 1'b1;
            end else if (clr_en && (clr_line == IDX_W'(i))) begin
                w_valid_next[i] = 1'b0;
            end
        end
    end

    // Valid flops, falling-edge clocked
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    assign valid_bits = r_valid;
    assign hit        = r_valid[lookup_line];

endmodule
`default_nettype wire

// File: rtl/cache_line_valid_fill.sv
`default_nettype none
// ============================================================================
//  Module      : cache_line_valid_fill
//  Description : Per-line valid bits with lookup, invalidate and flush, plus
//                a line-fill sequencer that fetches a whole line over a
//                req/ack byte bus, writes it to cache RAM, and marks the line
//                valid only after a complete, uncancelled fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_line_valid_fill
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = c_default_num_lines,
    parameter int LINE_BYTES = c_default_line_bytes,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 flush,
    input  logic                 inval,
    input  logic [IDX_W-1:0]     inval_line,
    input  logic [IDX_W-1:0]     lookup_line,
    output logic                 hit,
    input  logic                 fill_start,
    input  logic [IDX_W-1:0]     fill_line,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 mem_req,
    output logic [OFF_W-1:0]     mem_off,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_data,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     wr_line,
    output logic [OFF_W-1:0]     wr_off,
    output logic [7:0]           wr_data,
    output logic [NUM_LINES-1:0] valid_bits
);

    localparam logic [OFF_W-1:0] c_last_off = OFF_W'(LINE_BYTES - 1);

    fill_state_t      r_state;
    logic [IDX_W-1:0] r_fill_line;
    logic [OFF_W-1:0] r_cnt;
    logic             r_kill;
    logic             r_mem_req;
    logic             r_fill_done;
    logic             r_wr_en;
    logic [IDX_W-1:0] r_wr_line;
    logic [OFF_W-1:0] r_wr_off;
    logic [7:0]       r_wr_data;

    logic             w_start;
    logic             w_commit_set;
    logic             w_kill_hit;

    // A new fill only starts from IDLE and never alongside a flush
    assign w_start      = (r_state == IDLE) && fill_start && !flush;
    // The line becomes valid at COMMIT unless it was invalidated mid-fill
    assign w_commit_set = (r_state == COMMIT) && !r_kill;
    // Invalidate aimed at the line currently being filled
    assign w_kill_hit   = inval && (inval_line == r_fill_line);

    // Fill sequencer: IDLE -> FETCH (one byte per ack) -> COMMIT -> IDLE
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= IDLE;
            r_fill_line <= '0;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_fill_done <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_line   <= '0;
            r_wr_off    <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_fill_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_fill_line <= fill_line;
                        r_cnt       <= '0;
                        r_kill      <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    // An accepted byte is always written, even in a flush cycle
                    if (mem_ack) begin
                        r_wr_en   <= 1'b1;
                        r_wr_line <= r_fill_line;
                        r_wr_off  <= r_cnt;
                        r_wr_data <= mem_data;
                    end
                    if (w_kill_hit) begin
                        r_kill <= 1'b1;
                    end
                    if (flush) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end else if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last_off) begin
                            r_state     <= COMMIT;
                            r_mem_req   <= 1'b0;
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (w_kill_hit) begin
                        r_kill <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    cache_valid_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_valid (
        .clk         (clk),
        .clr_n       (clr_n),
        .flush       (flush),
        .inval       (inval),
        .inval_line  (inval_line),
        .set_en      (w_commit_set),
        .set_line    (r_fill_line),
        .clr_en      (w_start),
        .clr_line    (fill_line),
        .lookup_line (lookup_line),
        .hit         (hit),
        .valid_bits  (valid_bits)
    );

    assign fill_busy = (r_state != IDLE);
    assign fill_done = r_fill_done;
    assign mem_req   = r_mem_req;
    assign mem_off   = r_cnt;
    assign wr_en     = r_wr_en;
    assign wr_line   = r_wr_line;
    assign wr_off    = r_wr_off;
    assign wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_valid_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_line_valid_fill
//  Description : Scoreboard bench for cache_line_valid_fill. Stimulus pushes
//                expected writes, fill completions and deferred signal checks
//                into queues; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_valid_fill;

    localparam int K_VALID   = 0;
    localparam int K_HIT     = 1;
    localparam int K_BUSY    = 2;
    localparam int K_REQ     = 3;
    localparam int K_WREN    = 4;
    localparam int K_VAL     = 5;
    localparam int K_TIMEOUT = 6;

    typedef struct {
        int          kind;
        int          dut;
        int          tag;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    chk_t        cq[$];
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    int          dq0[$];
    int          dq1[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        fs   [2];
    logic [5:0]  fl   [2];
    logic        fls  [2];
    logic        inv  [2];
    logic [5:0]  invl [2];
    logic [5:0]  look [2];
    logic        ack  [2];
    logic [7:0]  md   [2];

    logic        sreq  [2];
    logic [5:0]  soff  [2];
    logic        sdone [2];
    logic [63:0] vm    [2];

    logic        hit_a, busy_a, done_a, req_a, wren_a;
    logic [3:0]  off_a, woff_a;
    logic [4:0]  wline_a;
    logic [7:0]  wdata_a;
    logic [31:0] valid_a;

    logic        hit_b, busy_b, done_b, req_b, wren_b;
    logic [2:0]  off_b, woff_b;
    logic [5:0]  wline_b;
    logic [7:0]  wdata_b;
    logic [63:0] valid_b;

    always #5 clk = ~clk;

    cache_line_valid_fill u_dut_a (
        .clk(clk), .clr_n(clr_n), .flush(fls[0]), .inval(inv[0]),
        .inval_line(invl[0][4:0]), .lookup_line(look[0][4:0]), .hit(hit_a),
        .fill_start(fs[0]), .fill_line(fl[0][4:0]), .fill_busy(busy_a),
        .fill_done(done_a), .mem_req(req_a), .mem_off(off_a), .mem_ack(ack[0]),
        .mem_data(md[0]), .wr_en(wren_a), .wr_line(wline_a), .wr_off(woff_a),
        .wr_data(wdata_a), .valid_bits(valid_a)
    );

    cache_line_valid_fill #(.NUM_LINES(64), .LINE_BYTES(8)) u_dut_b (
        .clk(clk), .clr_n(clr_n), .flush(fls[1]), .inval(inv[1]),
        .inval_line(invl[1]), .lookup_line(look[1]), .hit(hit_b),
        .fill_start(fs[1]), .fill_line(fl[1]), .fill_busy(busy_b),
        .fill_done(done_b), .mem_req(req_b), .mem_off(off_b), .mem_ack(ack[1]),
        .mem_data(md[1]), .wr_en(wren_b), .wr_line(wline_b), .wr_off(woff_b),
        .wr_data(wdata_b), .valid_bits(valid_b)
    );

    function automatic logic [63:0] pack(input int line, input int off, input logic [7:0] dat);
        return (64'(line) << 16) | (64'(off) << 8) | 64'(dat);
    endfunction

    function automatic logic [63:0] get_sig(input int kind, input int d);
        case (kind)
            K_VALID: return d != 0 ? valid_b : {32'd0, valid_a};
            K_HIT:   return 64'(d != 0 ? hit_b : hit_a);
            K_BUSY:  return 64'(d != 0 ? busy_b : busy_a);
            K_REQ:   return 64'(d != 0 ? req_b : req_a);
            default: return 64'(d != 0 ? wren_b : wren_a);
        endcase
    endfunction

    function automatic string cname(input int kind, input int tag);
        case (kind)
            K_VALID: return "valid_bits";
            K_HIT:   return "hit";
            K_BUSY:  return "fill_busy";
            K_REQ:   return "mem_req";
            K_WREN:  return "wr_en";
            K_TIMEOUT: return "fill_timeout";
            default: begin
                case (tag)
                    1: return "mem_off";
                    2: return "fill_done_at_commit";
                    3: return "fill_latency";
                    4: return "fetch_cycles";
                    5: return "writes_outstanding";
                    default: return "done_outstanding";
                endcase
            end
        endcase
    endfunction

    function automatic void chk_later(input int kind, input int d, input logic [63:0] exp);
        cq.push_back('{kind, d, 0, 64'd0, exp});
    endfunction

    function automatic void chk_val(input int tag, input logic [63:0] act, input logic [63:0] exp);
        cq.push_back('{K_VAL, 0, tag, act, exp});
    endfunction

    // Monitor: pops expected writes / completions and deferred checks
    always @(posedge clk) begin
        chk_t        it;
        logic [63:0] a;
        logic [63:0] e;
        if (wren_a) begin
            n_total++;
            a = pack(int'(wline_a), int'(woff_a), wdata_a);
            if (wq0.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected dut=0 got=%0h want=none", a);
            end else begin
                e = wq0.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL wr_write dut=0 got=%0h want=%0h", a, e);
                end
            end
        end
        if (wren_b) begin
            n_total++;
            a = pack(int'(wline_b), int'(woff_b), wdata_b);
            if (wq1.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected dut=1 got=%0h want=none", a);
            end else begin
                e = wq1.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL wr_write dut=1 got=%0h want=%0h", a, e);
                end
            end
        end
        if (done_a) begin
            n_total++;
            if (dq0.size() == 0) begin
                n_bad++;
                $display("FAIL fill_done_unexpected dut=0 got=1 want=0");
            end else begin
                e = 64'(dq0.pop_front());
                if (64'(wline_a) !== e) begin
                    n_bad++;
                    $display("FAIL fill_done_line dut=0 got=%0d want=%0d", wline_a, e);
                end
            end
        end
        if (done_b) begin
            n_total++;
            if (dq1.size() == 0) begin
                n_bad++;
                $display("FAIL fill_done_unexpected dut=1 got=1 want=0");
            end else begin
                e = 64'(dq1.pop_front());
                if (64'(wline_b) !== e) begin
                    n_bad++;
                    $display("FAIL fill_done_line dut=1 got=%0d want=%0d", wline_b, e);
                end
            end
        end
        while (cq.size() > 0) begin
            it = cq.pop_front();
            a  = (it.kind == K_VAL || it.kind == K_TIMEOUT) ? it.act : get_sig(it.kind, it.dut);
            n_total++;
            if (a !== it.exp) begin
                n_bad++;
                $display("FAIL %s dut=%0d got=%0h want=%0h", cname(it.kind, it.tag), it.dut, a, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        sreq[0]  = req_a;
        sreq[1]  = req_b;
        soff[0]  = {2'b00, off_a};
        soff[1]  = {3'b000, off_b};
        sdone[0] = done_a;
        sdone[1] = done_b;
        #1;
    endtask

    task automatic push_wr(input int d, input logic [63:0] v);
        if (d != 0) wq1.push_back(v);
        else        wq0.push_back(v);
    endtask

    task automatic push_done(input int d, input int line);
        if (d != 0) dq1.push_back(line);
        else        dq0.push_back(line);
    endtask

    // One fill transaction against a reference of line-level rules
    task automatic run_fill(input int d, input int line, input int mode, input int dbase,
                            input int inval_at, input int inval_ln, input int flush_at,
                            input bit hold_start, input bit inval_commit, input int reset_at);
        int         lb = (d != 0) ? 8 : 16;
        int         nl = (d != 0) ? 64 : 32;
        int         acks = 0;
        int         acks0;
        int         reqc = 0;
        int         iter = 0;
        int         c0;
        bit         kill = 1'b0;
        bit         inv_done = 1'b0;
        bit         a;
        logic [7:0] dat;
        fs[d]   = 1'b1;
        fl[d]   = 6'(line);
        look[d] = 6'(line);
        vm[d][line] = 1'b0;
        chk_later(K_HIT, d, 64'd0);
        c0 = cyc;
        step();
        fs[d] = hold_start;
        fl[d] = 6'((line + 1) % nl);
        forever begin
            iter++;
            ack[d] = 1'b0;
            inv[d] = 1'b0;
            fls[d] = 1'b0;
            if (iter > 64 * lb) begin
                cq.push_back('{K_TIMEOUT, d, 0, 64'd0, 64'd1});
                fs[d] = 1'b0;
                return;
            end
            if (sreq[d]) begin
                acks0 = acks;
                chk_val(1, 64'(soff[d]), 64'(acks));
                reqc++;
                if (acks == reset_at) begin
                    fs[d] = 1'b0;
                    step();
                    @(negedge clk);
                    #1;
                    clr_n = 1'b0;
                    vm[0] = '0;
                    vm[1] = '0;
                    chk_later(K_VALID, d, 64'd0);
                    chk_later(K_BUSY, d, 64'd0);
                    chk_later(K_REQ, d, 64'd0);
                    chk_later(K_WREN, d, 64'd0);
                    step();
                    step();
                    clr_n = 1'b1;
                    step();
                    return;
                end
                case (mode)
                    0:       a = 1'b1;
                    1:       a = (reqc % 3 == 0);
                    default: a = 1'($urandom_range(0, 1));
                endcase
                if (acks == inval_at && !inv_done) begin
                    inv_done = 1'b1;
                    inv[d]   = 1'b1;
                    invl[d]  = 6'(inval_ln);
                    vm[d][inval_ln] = 1'b0;
                    if (inval_ln == line) kill = 1'b1;
                end
                if (a) begin
                    dat    = (dbase >= 0) ? 8'(dbase + acks) : 8'($urandom);
                    ack[d] = 1'b1;
                    md[d]  = dat;
                    push_wr(d, pack(line, acks, dat));
                    acks++;
                end
                if (acks0 == flush_at) begin
                    fls[d] = 1'b1;
                    vm[d]  = '0;
                    chk_later(K_BUSY, d, 64'd0);
                    chk_later(K_VALID, d, 64'd0);
                    step();
                    chk_val(1, 64'(sreq[d]), 64'd0);
                    fls[d] = 1'b0;
                    fs[d]  = 1'b0;
                    ack[d] = 1'b0;
                    inv[d] = 1'b0;
                    step();
                    return;
                end
                if (acks == lb) begin
                    push_done(d, line);
                    step();
                    chk_val(2, 64'(sdone[d]), 64'd1);
                    if (mode == 0) chk_val(3, 64'(cyc - c0), 64'(lb + 1));
                    if (mode == 1) chk_val(4, 64'(reqc), 64'(3 * lb));
                    ack[d] = 1'b0;
                    inv[d] = 1'b0;
                    fs[d]  = 1'b0;
                    if (inval_commit) begin
                        inv[d]  = 1'b1;
                        invl[d] = 6'(line);
                        kill    = 1'b1;
                    end
                    if (!kill) vm[d][line] = 1'b1;
                    look[d] = 6'(line);
                    chk_later(K_VALID, d, vm[d]);
                    chk_later(K_HIT, d, 64'(!kill));
                    chk_later(K_BUSY, d, 64'd0);
                    step();
                    inv[d] = 1'b0;
                    return;
                end
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            fs[d] = 1'b0; fl[d] = '0; fls[d] = 1'b0; inv[d] = 1'b0;
            invl[d] = '0; look[d] = '0; ack[d] = 1'b0; md[d] = '0;
            vm[d] = '0;
        end
        repeat (3) step();
        clr_n = 1'b1;
        chk_later(K_VALID, 0, 64'd0);
        chk_later(K_BUSY, 0, 64'd0);
        chk_later(K_REQ, 0, 64'd0);
        chk_later(K_WREN, 0, 64'd0);
        chk_later(K_VALID, 1, 64'd0);
        step();
        step();

        // Line 5, ack every cycle, data = offset + 0x40
        run_fill(0, 5, 0, 'h40, -1, 0, -1, 1'b0, 1'b0, -1);
        // Line 3, ack every third request cycle
        run_fill(0, 3, 1, -1, -1, 0, -1, 1'b0, 1'b0, -1);
        // Line 7 valid, then refilled with an invalidate at offset 8
        run_fill(0, 7, 0, -1, -1, 0, -1, 1'b0, 1'b0, -1);
        run_fill(0, 7, 2, -1, 8, 7, -1, 1'b0, 1'b0, -1);
        // Line 2 valid, then flush at offset 4 of a fill of line 9 with fill_start held
        run_fill(0, 2, 0, -1, -1, 0, -1, 1'b0, 1'b0, -1);
        run_fill(0, 9, 0, -1, -1, 0, 4, 1'b1, 1'b0, -1);
        // fill_start and flush together in IDLE: nothing starts, all bits clear
        run_fill(0, 12, 0, -1, -1, 0, -1, 1'b0, 1'b0, -1);
        fs[0]  = 1'b1;
        fl[0]  = 6'd11;
        fls[0] = 1'b1;
        vm[0]  = '0;
        chk_later(K_BUSY, 0, 64'd0);
        chk_later(K_REQ, 0, 64'd0);
        chk_later(K_VALID, 0, 64'd0);
        step();
        fs[0]  = 1'b0;
        fls[0] = 1'b0;
        chk_later(K_BUSY, 0, 64'd0);
        step();

        // Randomised fills with stray invalidates and occasional flushes
        for (int i = 0; i < 12; i++) begin
            int ln, ia, il, fa;
            ln = int'($urandom_range(0, 31));
            ia = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            il = ($urandom_range(0, 1) == 0) ? ln : int'($urandom_range(0, 31));
            fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_fill(0, ln, int'($urandom_range(0, 2)), -1, ia, il, fa, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        // Second geometry: 64 lines of 8 bytes
        run_fill(1, 63, 0, 'h80, -1, 0, -1, 1'b0, 1'b0, -1);
        run_fill(1, 10, 2, -1, -1, 0, -1, 1'b0, 1'b0, -1);
        run_fill(1, 63, 0, -1, -1, 0, -1, 1'b0, 1'b1, -1);

        // Reset in the middle of FETCH with other lines valid
        run_fill(0, 1, 0, -1, -1, 0, -1, 1'b0, 1'b0, -1);
        run_fill(0, 6, 1, -1, -1, 0, -1, 1'b0, 1'b0, 5);
        run_fill(0, 4, 0, -1, -1, 0, -1, 1'b0, 1'b0, -1);

        repeat (3) step();
        chk_val(5, 64'(wq0.size() + wq1.size()), 64'd0);
        chk_val(6, 64'(dq0.size() + dq1.size()), 64'd0);
        step();
        step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_line_valid_fill.md
Name: cache_line_valid_fill

Overview:
- Parametrised successor to the SuperFX instruction-cache tag/dirty-bit latches.
- Holds one valid bit per cache line and provides binary-indexed lookup.
- Adds single-line invalidate and a global flush.
- Contains a line-fill sequencer that fetches LINE_BYTES bytes from the ROM/RAM bus via req/ack, writes them into cache RAM, and marks the line valid only after a complete, uncancelled fill.

Parameters:
- NUM_LINES, 32: number of cache lines; power of two, at least 2.
- LINE_BYTES, 16: bytes per line; power of two, at least 2.
- IDX_W, $clog2(NUM_LINES): line index width (derived; do not override).
- OFF_W, $clog2(LINE_BYTES): byte offset width (derived; do not override).

Ports:
- clk, in, 1: main clock. All state updates on the falling edge.
- clr_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous clear of all valid bits; aborts any fill.
- inval, in, 1: synchronous clear of one line.
- inval_line, in, IDX_W: line to invalidate.
- lookup_line, in, IDX_W: line being probed.
- hit, out, 1: combinational, valid_bits[lookup_line].
- fill_start, in, 1: request a fill of fill_line.
- fill_line, in, IDX_W: line to fill.
- fill_busy, out, 1: sequencer not in IDLE.
- fill_done, out, 1: one-cycle pulse on fill completion.
- mem_req, out, 1: byte fetch request.
- mem_off, out, OFF_W: byte offset within line for the current fetch.
- mem_ack, in, 1: fetch accepted; mem_data valid this cycle.
- mem_data, in, 8: fetched byte.
- wr_en, out, 1: registered cache-RAM write strobe.
- wr_line, out, IDX_W: registered write address (line).
- wr_off, out, OFF_W: registered write address (offset).
- wr_data, out, 8: registered write data.
- valid_bits, out, NUM_LINES: registered valid array.

Behaviour:
- Reset (clr_n=0, async):
  - valid_bits=0; state=IDLE.
  - mem_req=0, mem_off=0; wr_en=0, wr_line=0, wr_off=0, wr_data=0.
  - fill_done=0; internal kill flag=0.
- Valid-bit priority per falling edge, highest first:
  1. flush clears all bits.
  2. inval clears bit inval_line.
  3. COMMIT sets bit fill_line_q, unless kill=1.
  4. Starting a fill clears bit fill_line, so a partially filled line never hits.
  - Bits not addressed are unchanged.
- States:
  - IDLE: fill_busy=0. On fill_start=1 and flush=0, latch fill_line_q, clear the offset counter and kill, go to FETCH. fill_start is ignored in every non-IDLE state.
  - FETCH: mem_req=1, mem_off=counter; mem_off is held stable until mem_ack. On mem_ack, register wr_en=1 with wr_line=fill_line_q, wr_off=counter, wr_data=mem_data, so writes appear one cycle after ack. Then increment counter. If counter=LINE_BYTES-1 on ack, go to COMMIT.
  - COMMIT: mem_req=0; fill_done=1 for exactly one cycle; valid set per priority; go to IDLE. The last wr_en pulse coincides with COMMIT. hit for the line is visible from the cycle after COMMIT.
- Kill flag: set when inval=1 and inval_line=fill_line_q in FETCH or COMMIT. The fill still runs to completion and writes all bytes, but the valid bit is not set. fill_done still pulses.
- flush in FETCH or COMMIT:
  - Immediate return to IDLE; mem_req drops on the next edge.
  - No fill_done; no further wr_en, except a wr_en already registered from an ack in the flush cycle.
- fill_start and flush in the same IDLE cycle: flush wins, no fill starts.
- Minimum fill latency with mem_ack tied high: LINE_BYTES FETCH cycles plus 1 COMMIT cycle.
- mem_ack outside FETCH is ignored.
- Counter is OFF_W bits; wrap-around is never reached because COMMIT is entered on the last offset.
- Reset mid-fill returns everything to reset values immediately; no valid bit is set.

Decomposition:
- Shared package cache_pkg:
  - Fill-state enum: IDLE, FETCH, COMMIT.
  - Default NUM_LINES and LINE_BYTES constants, shared with the cache RAM and tag blocks.
- One natural sub-module: cache_valid_array. It holds the valid flops and the flush/inval/set/clear priority logic, with binary-indexed ports.
- The sequencer stays in the top module.

Test Plan:
- Reset with clr_n=0 mid-FETCH: valid_bits=0, mem_req=0, wr_en=0, fill_busy=0 asynchronously.
- Fill line 5 with mem_ack always 1 and mem_data=offset+0x40:
  - 16 wr_en pulses with wr_line=5, wr_off 0..15, data 0x40..0x4F.
  - fill_done on cycle 17; valid_bits=0x0000_0020; hit=1 for lookup_line=5.
- Fill line 3 with mem_ack asserted every third cycle: mem_off is held between acks; completes after 48 FETCH cycles + COMMIT; line 3 becomes valid.
- Fill line 7 while line 7 is valid: hit drops the cycle after start. At offset 8, assert inval on line 7: fill_done pulses and bit 7 stays 0.
- flush at offset 4 of a fill of line 9 with line 2 valid: all valid bits clear, state IDLE, no fill_done. fill_start held during busy is ignored; fill_start and flush in the same IDLE cycle start nothing.
- Parameter sweep NUM_LINES=64, LINE_BYTES=8: fill line 63 gives 8 writes and valid_bits[63]=1. Simultaneous inval of line 63 and COMMIT leaves the bit 0.
